// File: rtl/lsu_spu_reqack_pkg.sv
// Shared constants for the LSU-side SPU MA request/ack responder.
// CPX return types, packet store bit, FSM encoding, MA thread id.
package lsu_spu_reqack_pkg;

  localparam logic [3:0] RTN_LD = 4'b0010;
  localparam logic [3:0] RTN_ST = 4'b0100;

  localparam int ST_BIT = 118;

  localparam logic [1:0] MA_TID = 2'b00;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  function automatic logic [1:0] cmplt_cnt(input logic dbl);
    return dbl ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lsu_spu_stcnt.sv
// Outstanding MA store counter: +1 per store ack, -0..2 per completion.
// Saturates at zero; sticky underflow when completions exceed count.
module lsu_spu_stcnt #(
  parameter int MAX_OUT = 32,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             uflow
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  logic [CNT_W:0] sum;
  logic [CNT_W:0] dec_w;

  assign sum   = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
  assign dec_w = {{(CNT_W-1){1'b0}}, dec};
  assign full  = (cnt >= MAX_C);

  // count update and sticky underflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      uflow <= 1'b0;
    end else begin
      if (dec_w > sum)
        cnt <= '0;
      else
        cnt <= CNT_W'(sum - dec_w);
      if (dec_w > {1'b0, cnt})
        uflow <= 1'b1;
    end
  end

endmodule

// File: rtl/lsu_spu_reqack.sv
// LSU responder for SPU MA ld/st: PCX request, ld/st ack pulses,
// CPX load return forwarding and streaming-store completion count.
module lsu_spu_reqack
  import lsu_spu_reqack_pkg::*;
#(
  parameter int MAX_OUT = 32,
  parameter int CNT_W   = 6
) (
  input  logic           rclk,
  input  logic           arst_l,
  input  logic           se,
  input  logic           spu_lsu_ldst_pcx_vld,
  input  logic [122:104] spu_lsu_pckt_req,
  input  logic           pcx_lsu_grant,
  output logic           lsu_pcx_spu_req,
  output logic           lsu_pcx_spu_store,
  input  logic           cpx_spu_vld,
  input  logic [3:0]     cpx_spu_rtntyp,
  input  logic           cpx_spu_dbl,
  input  logic [1:0]     cpx_spu_err,
  output logic           lsu_spu_ld_ackvld,
  output logic           lsu_spu_st_ackvld,
  output logic [1:0]     lsu_spu_ld_ack_tid,
  output logic [1:0]     lsu_spu_st_ack_tid,
  output logic           lsu_spu_ld_asop,
  output logic           lsu_spu_st_asop,
  output logic           lsu_spu_vload_vld,
  output logic [3:0]     lsu_spu_vload_rtntyp,
  output logic [1:0]     lsu_spu_l2_err,
  output logic [1:0]     lsu_spu_strm_ack_cmplt,
  output logic           lsu_spu_stack_uflow
);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             is_store;
  logic             full;
  logic [CNT_W-1:0] st_cnt;
  logic             busy;
  logic             cpx_ld;
  logic             cpx_st;
  logic             unused;

  // scan enable, header bits other than the store bit, and the raw
  // count are not needed by the request logic
  assign unused = ^{se, spu_lsu_pckt_req, st_cnt};

  // next state; a store is held off while the store window is full
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (spu_lsu_ldst_pcx_vld &&
            !(spu_lsu_pckt_req[ST_BIT] && full))
          state_nx = S_REQ;
      S_REQ:
        if (pcx_lsu_grant)
          state_nx = S_ACK;
      S_ACK:
        state_nx = S_HOLD;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // state register and request type capture
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state    <= S_IDLE;
      is_store <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && state_nx == S_REQ)
        is_store <= spu_lsu_pckt_req[ST_BIT];
    end
  end

  assign busy = (state != S_IDLE);

  assign lsu_pcx_spu_req   = (state == S_REQ);
  assign lsu_pcx_spu_store = lsu_pcx_spu_req & is_store;

  assign lsu_spu_ld_ackvld = (state == S_ACK) & ~is_store;
  assign lsu_spu_st_ackvld = (state == S_ACK) & is_store;

  assign lsu_spu_ld_ack_tid = MA_TID;
  assign lsu_spu_st_ack_tid = MA_TID;

  // asop rises with REQ so it leads the ack pulse by a cycle
  assign lsu_spu_ld_asop = busy & ~is_store;
  assign lsu_spu_st_asop = busy & is_store;

  assign cpx_ld = cpx_spu_vld && (cpx_spu_rtntyp == RTN_LD);
  assign cpx_st = cpx_spu_vld && (cpx_spu_rtntyp == RTN_ST);

  // registered CPX return forwarding
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      lsu_spu_vload_vld      <= 1'b0;
      lsu_spu_vload_rtntyp   <= '0;
      lsu_spu_l2_err         <= '0;
      lsu_spu_strm_ack_cmplt <= '0;
    end else begin
      lsu_spu_vload_vld      <= cpx_ld;
      lsu_spu_vload_rtntyp   <= cpx_ld ? RTN_LD : 4'b0000;
      lsu_spu_l2_err         <= cpx_ld ? cpx_spu_err : 2'b00;
      lsu_spu_strm_ack_cmplt <= cpx_st ? cmplt_cnt(cpx_spu_dbl)
                                       : 2'b00;
    end
  end

  lsu_spu_stcnt #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_stcnt (
    .clk   (rclk),
    .rst_n (arst_l),
    .inc   (lsu_spu_st_ackvld),
    .dec   (lsu_spu_strm_ack_cmplt),
    .cnt   (st_cnt),
    .full  (full),
    .uflow (lsu_spu_stack_uflow)
  );

endmodule

// File: tb/tb_lsu_spu_reqack.sv
// Bench for lsu_spu_reqack: directed + random traffic, scoreboard
// queues for acks and CPX returns, abstract store-count model.
module tb_lsu_spu_reqack;

  localparam int MAX_OUT = 32;

  logic           rclk = 1'b0;
  logic           arst_l = 1'b0;
  logic           se = 1'b0;
  logic           spu_vld = 1'b0;
  logic [122:104] pckt = '0;
  logic           grant = 1'b0;
  logic           pcx_req;
  logic           pcx_store;
  logic           cpx_vld = 1'b0;
  logic [3:0]     cpx_rt = '0;
  logic           cpx_dbl = 1'b0;
  logic [1:0]     cpx_err = '0;
  logic           ld_ack;
  logic           st_ack;
  logic [1:0]     ld_tid;
  logic [1:0]     st_tid;
  logic           ld_asop;
  logic           st_asop;
  logic           vl_vld;
  logic [3:0]     vl_rt;
  logic [1:0]     l2_err;
  logic [1:0]     cmplt;
  logic           uflow;

  lsu_spu_reqack #(.MAX_OUT(MAX_OUT), .CNT_W(6)) dut (
    .rclk                   (rclk),
    .arst_l                 (arst_l),
    .se                     (se),
    .spu_lsu_ldst_pcx_vld   (spu_vld),
    .spu_lsu_pckt_req       (pckt),
    .pcx_lsu_grant          (grant),
    .lsu_pcx_spu_req        (pcx_req),
    .lsu_pcx_spu_store      (pcx_store),
    .cpx_spu_vld            (cpx_vld),
    .cpx_spu_rtntyp         (cpx_rt),
    .cpx_spu_dbl            (cpx_dbl),
    .cpx_spu_err            (cpx_err),
    .lsu_spu_ld_ackvld      (ld_ack),
    .lsu_spu_st_ackvld      (st_ack),
    .lsu_spu_ld_ack_tid     (ld_tid),
    .lsu_spu_st_ack_tid     (st_tid),
    .lsu_spu_ld_asop        (ld_asop),
    .lsu_spu_st_asop        (st_asop),
    .lsu_spu_vload_vld      (vl_vld),
    .lsu_spu_vload_rtntyp   (vl_rt),
    .lsu_spu_l2_err         (l2_err),
    .lsu_spu_strm_ack_cmplt (cmplt),
    .lsu_spu_stack_uflow    (uflow)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    bit st;
    int tag;
  } ack_t;

  typedef struct {
    bit       v;
    bit [3:0] rt;
    bit [1:0] er;
    bit [1:0] cm;
    int       tag;
  } exp_t;

  ack_t ack_q[$];
  exp_t exp_q[$];
  int   inc_at[int];
  int   dec_at[int];
  int   cyc = 0;
  int   mcnt = 0;
  bit   muflow = 1'b0;
  int   tests = 0;
  int   fails = 0;

  function automatic void check(input string nm, input int act,
                                input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  always @(posedge rclk) cyc <= cyc + 1;

  // monitor: store-count model, CPX return and ack scoreboards
  always @(negedge rclk) begin
    int   d;
    int   i;
    exp_t e;
    bit   have;
    if (!arst_l) begin
      mcnt   = 0;
      muflow = 1'b0;
      ack_q.delete();
    end else begin
      d = dec_at.exists(cyc) ? dec_at[cyc] : 0;
      i = inc_at.exists(cyc) ? inc_at[cyc] : 0;
      if (d > mcnt) muflow = 1'b1;
      mcnt = (mcnt + i - d < 0) ? 0 : mcnt + i - d;
    end
    while (exp_q.size() > 0 && exp_q[0].tag < cyc - 1)
      void'(exp_q.pop_front());
    have = 1'b0;
    e = '{v: 1'b0, rt: 4'b0, er: 2'b0, cm: 2'b0, tag: 0};
    if (exp_q.size() > 0 && exp_q[0].tag == cyc - 1) begin
      e = exp_q.pop_front();
      have = 1'b1;
    end
    if (arst_l && (have || vl_vld || cmplt != 2'b00 || l2_err != 2'b00)) begin
      check("vload_vld", int'(vl_vld), int'(e.v));
      check("vload_rtntyp", int'(vl_rt), int'(e.rt));
      check("l2_err", int'(l2_err), int'(e.er));
      check("strm_ack_cmplt", int'(cmplt), int'(e.cm));
    end
    if (ld_ack || st_ack) begin
      check("ack_onehot", int'(ld_ack & st_ack), 0);
      if (ack_q.size() > 0 && ack_q[0].tag == cyc) begin
        ack_t a;
        a = ack_q.pop_front();
        check("ack_is_store", int'(st_ack), int'(a.st));
        check("ack_tid", int'({ld_tid, st_tid}), 0);
        check("ack_asop", int'(a.st ? st_asop : ld_asop), 1);
      end else begin
        check("ack_unexpected", 1, 0);
      end
    end else if (ack_q.size() > 0 && ack_q[0].tag <= cyc) begin
      void'(ack_q.pop_front());
      check("ack_missing", 0, 1);
    end
  end

  // one clock: record expected CPX response, then clear pulses
  task automatic tick();
    exp_t e;
    bit   ld;
    bit   st;
    ld = cpx_vld && cpx_rt == 4'b0010;
    st = cpx_vld && cpx_rt == 4'b0100;
    e.v   = ld;
    e.rt  = ld ? 4'b0010 : 4'b0000;
    e.er  = ld ? cpx_err : 2'b00;
    e.cm  = st ? (cpx_dbl ? 2'b10 : 2'b01) : 2'b00;
    e.tag = cyc;
    exp_q.push_back(e);
    if (st) dec_at[cyc + 1] = int'(e.cm);
    @(posedge rclk);
    #1;
    cpx_vld = 1'b0;
    cpx_rt  = 4'b0000;
    cpx_dbl = 1'b0;
    cpx_err = 2'b00;
    grant   = 1'b0;
  endtask

  task automatic settle_chk(input string nm);
    repeat (3) tick();
    check({nm, "_cnt"}, int'(dut.u_stcnt.cnt), mcnt);
    check({nm, "_uflow"}, int'(uflow), int'(muflow));
  endtask

  task automatic do_req(input bit st, input int gdly, input bit dbl_g);
    int n;
    int reqc;
    spu_vld = 1'b1;
    pckt = 19'($urandom);
    pckt[118] = st;
    n = 0;
    tick();
    while (!pcx_req && n < 40) begin
      tick();
      n++;
    end
    check("pcx_req_rise", int'(pcx_req), 1);
    if (!pcx_req) begin
      spu_vld = 1'b0;
      return;
    end
    check("pcx_store", int'(pcx_store), int'(st));
    check("asop_in_req", int'(st ? st_asop : ld_asop), 1);
    check("asop_other", int'(st ? ld_asop : st_asop), 0);
    check("tid_in_req", int'({ld_tid, st_tid}), 0);
    reqc = 1;
    repeat (gdly) begin
      tick();
      reqc += int'(pcx_req);
    end
    grant = 1'b1;
    if (dbl_g) begin
      cpx_vld = 1'b1;
      cpx_rt  = 4'b0100;
      cpx_dbl = 1'b1;
    end
    if (st) inc_at[cyc + 1] = 1;
    ack_q.push_back('{st: st, tag: cyc + 1});
    tick();
    check("req_len", reqc, gdly + 1);
    check("req_drop", int'(pcx_req), 0);
    spu_vld = 1'b0;
    tick();
    tick();
    check("asop_idle", int'({ld_asop, st_asop}), 0);
  endtask

  task automatic apply_reset();
    arst_l  = 1'b0;
    spu_vld = 1'b0;
    repeat (2) tick();
    arst_l = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int r;
    int t;
    // reset state
    repeat (2) tick();
    check("rst_req", int'({pcx_req, pcx_store}), 0);
    check("rst_ack", int'({ld_ack, st_ack, ld_asop, st_asop}), 0);
    check("rst_cpx", int'({vl_vld, vl_rt, l2_err, cmplt}), 0);
    check("rst_uflow", int'(uflow), 0);
    arst_l = 1'b1;
    repeat (2) tick();

    // load, grant in third REQ cycle
    do_req(1'b0, 2, 1'b0);
    settle_chk("load");

    // store granted at once, then a single completion
    do_req(1'b1, 0, 1'b0);
    settle_chk("store1");
    check("store1_one", int'(dut.u_stcnt.cnt), 1);
    cpx_vld = 1'b1;
    cpx_rt  = 4'b0100;
    tick();
    settle_chk("cmplt1");
    check("cmplt1_zero", int'(dut.u_stcnt.cnt), 0);

    // CPX load return with uncorrectable error
    cpx_vld = 1'b1;
    cpx_rt  = 4'b0010;
    cpx_err = 2'b10;
    tick();
    repeat (3) tick();

    // fill the store window, 33rd store stalls
    repeat (MAX_OUT) do_req(1'b1, 0, 1'b0);
    settle_chk("full");
    spu_vld = 1'b1;
    pckt = 19'($urandom);
    pckt[118] = 1'b1;
    repeat (5) begin
      tick();
      check("stall_no_req", int'(pcx_req), 0);
    end
    cpx_vld = 1'b1;
    cpx_rt  = 4'b0100;
    cpx_dbl = 1'b1;
    tick();
    do_req(1'b1, 1, 1'b0);
    settle_chk("unstall");
    check("unstall_31", int'(dut.u_stcnt.cnt), 31);

    // simultaneous store ack and double completion at count 3
    apply_reset();
    repeat (3) do_req(1'b1, 0, 1'b0);
    settle_chk("three");
    do_req(1'b1, 1, 1'b1);
    settle_chk("simul");
    check("simul_two", int'(dut.u_stcnt.cnt), 2);

    // completion with nothing outstanding
    apply_reset();
    cpx_vld = 1'b1;
    cpx_rt  = 4'b0100;
    tick();
    settle_chk("uflow");
    check("uflow_set", int'(uflow), 1);
    do_req(1'b0, 0, 1'b0);
    check("uflow_sticky", int'(uflow), 1);

    // reset while requesting
    apply_reset();
    spu_vld = 1'b1;
    pckt = '0;
    pckt[118] = 1'b1;
    tick();
    tick();
    check("mid_req_up", int'(pcx_req), 1);
    arst_l = 1'b0;
    #1;
    check("mid_req_drop", int'(pcx_req), 0);
    spu_vld = 1'b0;
    repeat (2) tick();
    arst_l = 1'b1;
    settle_chk("mid_rst");
    check("mid_rst_zero", int'(dut.u_stcnt.cnt), 0);

    // random traffic
    for (int k = 0; k < 120; k++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0, 1: do_req(1'b0, int'($urandom_range(0, 3)), 1'b0);
        2: if (mcnt < MAX_OUT)
             do_req(1'b1, int'($urandom_range(0, 3)),
                    (mcnt >= 2) && $urandom_range(0, 1) == 1);
        3: begin
          cpx_vld = 1'b1;
          cpx_rt  = 4'b0010;
          cpx_err = 2'($urandom);
          cpx_dbl = 1'($urandom);
          tick();
        end
        4: if (mcnt > 0) begin
          cpx_vld = 1'b1;
          cpx_rt  = 4'b0100;
          cpx_dbl = (mcnt >= 2) && $urandom_range(0, 1) == 1;
          tick();
        end
        default: begin
          t = int'($urandom_range(0, 15));
          if (t == 2 || t == 4) t = 8;
          cpx_vld = 1'($urandom);
          cpx_rt  = 4'(t);
          cpx_err = 2'($urandom);
          cpx_dbl = 1'($urandom);
          grant   = 1'($urandom);
          tick();
        end
      endcase
      settle_chk("rand");
    end

    repeat (3) tick();
    check("acks_drained", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
